// File: rtl/axi4_master_engine.sv
// AXI4 initiator engine: a valid/ready command port feeds the AW/AR channels,
// a write-beat port feeds W, and B/R are merged into one response port.
// The AW/AR/W/response stages are registered. Each direction limits the number
// of in-flight bursts to MAX_OUTSTANDING.
// Optional build macro AXI4_MASTER_ENGINE_ERRCNT_EN adds the err_cnt/err_flag
// outputs, which count SLVERR/DECERR responses.
module axi4_master_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_last,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [ID_WIDTH-1:0]     ARID,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
`ifdef AXI4_MASTER_ENGINE_ERRCNT_EN
  ,
  output logic [15:0]             err_cnt,
  output logic                    err_flag
`endif
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   MAX_OCC  = (CW + 1)'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  // Up/down counter step; simultaneous inc/dec holds, decrement saturates at zero.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CW'(1'b1);
    end else if (dec && !inc && (cnt != {CW{1'b0}})) begin
      res = cnt - CW'(1'b1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Circular pointer advance for the len FIFO (depth need not fill the pointer).
  function automatic logic [PW-1:0] ptr_step(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  logic [CW-1:0] wr_cnt_r, rd_cnt_r, len_cnt_r;
  logic [CW:0]   wr_occ_s, rd_occ_s;
  logic [7:0]    len_mem_r [MAX_OUTSTANDING];
  logic [PW-1:0] len_wp_r, len_rp_r, head_ptr_s;
  logic [7:0]    head_len_s, beat_r;
  logic          head_ok_s, beat_last_s;
  logic          cmd_hs_s, aw_hs_s, ar_hs_s, wd_hs_s, w_pop_s, b_hs_s, r_hs_s, rsp_free_s;

  assign cmd_hs_s    = cmd_valid & cmd_ready;
  assign aw_hs_s     = AWVALID & AWREADY;
  assign ar_hs_s     = ARVALID & ARREADY;
  assign wd_hs_s     = wd_valid & wd_ready;
  assign w_pop_s     = WVALID & WREADY & WLAST;
  assign b_hs_s      = BVALID & BREADY;
  assign r_hs_s      = RVALID & RREADY;
  assign rsp_free_s  = !rsp_valid | rsp_ready;
  assign beat_last_s = (beat_r == head_len_s);

  // A pending AxVALID counts as in flight so a reloading slot cannot overshoot the limit.
  always_comb begin
    wr_occ_s = {1'b0, wr_cnt_r} + {{CW{1'b0}}, AWVALID};
    rd_occ_s = {1'b0, rd_cnt_r} + {{CW{1'b0}}, ARVALID};
    if (reset) begin
      cmd_ready = 1'b0;
    end else if (cmd_write) begin
      cmd_ready = (!AWVALID || AWREADY) && (wr_occ_s < MAX_OCC);
    end else begin
      cmd_ready = (!ARVALID || ARREADY) && (rd_occ_s < MAX_OCC);
    end
  end

  // Select the burst length that governs the next accepted write beat; while the
  // last beat of a burst waits in the W register, the following FIFO entry applies.
  always_comb begin
    if (WVALID && WLAST) begin
      head_ptr_s = ptr_step(len_rp_r);
      head_ok_s  = (len_cnt_r > CW'(1'b1));
    end else begin
      head_ptr_s = len_rp_r;
      head_ok_s  = (len_cnt_r != {CW{1'b0}});
    end
    head_len_s = len_mem_r[head_ptr_s];
    if (reset) begin
      wd_ready = 1'b0;
    end else begin
      wd_ready = (!WVALID || WREADY) && head_ok_s;
    end
  end

  // B wins over R; both are accepted only when the response register can take a beat.
  always_comb begin
    if (reset) begin
      BREADY = 1'b0;
      RREADY = 1'b0;
    end else begin
      BREADY = rsp_free_s;
      RREADY = rsp_free_s && !BVALID;
    end
  end

  // Write address stage: load on write command, hold payload until AWREADY.
  always_ff @(posedge clock) begin
    if (reset) begin
      AWVALID <= 1'b0;
      AWADDR  <= {ADDR_WIDTH{1'b0}};
      AWID    <= {ID_WIDTH{1'b0}};
      AWLEN   <= 8'h00;
      AWSIZE  <= 3'b000;
      AWBURST <= 2'b00;
    end else if (cmd_hs_s && cmd_write) begin
      AWVALID <= 1'b1;
      AWADDR  <= cmd_addr;
      AWID    <= cmd_id;
      AWLEN   <= cmd_len;
      AWSIZE  <= cmd_size;
      AWBURST <= cmd_burst;
    end else if (AWREADY) begin
      AWVALID <= 1'b0;
    end
  end

  // Read address stage: load on read command, hold payload until ARREADY.
  always_ff @(posedge clock) begin
    if (reset) begin
      ARVALID <= 1'b0;
      ARADDR  <= {ADDR_WIDTH{1'b0}};
      ARID    <= {ID_WIDTH{1'b0}};
      ARLEN   <= 8'h00;
      ARSIZE  <= 3'b000;
      ARBURST <= 2'b00;
    end else if (cmd_hs_s && !cmd_write) begin
      ARVALID <= 1'b1;
      ARADDR  <= cmd_addr;
      ARID    <= cmd_id;
      ARLEN   <= cmd_len;
      ARSIZE  <= cmd_size;
      ARBURST <= cmd_burst;
    end else if (ARREADY) begin
      ARVALID <= 1'b0;
    end
  end

  // Outstanding burst counters per direction.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt_r <= {CW{1'b0}};
      rd_cnt_r <= {CW{1'b0}};
    end else begin
      wr_cnt_r <= cnt_step(wr_cnt_r, aw_hs_s, b_hs_s);
      rd_cnt_r <= cnt_step(rd_cnt_r, ar_hs_s, r_hs_s && RLAST);
    end
  end

  // Length FIFO: AWLEN pushed at AW acceptance, popped at the WLAST handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        len_mem_r[i] <= 8'h00;
      end
      len_wp_r  <= {PW{1'b0}};
      len_rp_r  <= {PW{1'b0}};
      len_cnt_r <= {CW{1'b0}};
    end else begin
      if (aw_hs_s) begin
        len_mem_r[len_wp_r] <= AWLEN;
        len_wp_r            <= ptr_step(len_wp_r);
      end
      if (w_pop_s) begin
        len_rp_r <= ptr_step(len_rp_r);
      end
      len_cnt_r <= cnt_step(len_cnt_r, aw_hs_s, w_pop_s);
    end
  end

  // Write data stage with beat counter; WLAST is decided when the beat is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      WVALID <= 1'b0;
      WDATA  <= {DATA_WIDTH{1'b0}};
      WSTRB  <= {SW{1'b0}};
      WLAST  <= 1'b0;
      beat_r <= 8'h00;
    end else if (wd_hs_s) begin
      WVALID <= 1'b1;
      WDATA  <= wd_data;
      WSTRB  <= wd_strb;
      WLAST  <= beat_last_s;
      beat_r <= beat_last_s ? 8'h00 : beat_r + 8'h01;
    end else if (WREADY) begin
      WVALID <= 1'b0;
    end
  end

  // One-entry response register merging B completions and R beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_id    <= {ID_WIDTH{1'b0}};
      rsp_data  <= {DATA_WIDTH{1'b0}};
      rsp_resp  <= 2'b00;
      rsp_last  <= 1'b0;
    end else if (b_hs_s) begin
      rsp_valid <= 1'b1;
      rsp_write <= 1'b1;
      rsp_id    <= BID;
      rsp_data  <= {DATA_WIDTH{1'b0}};
      rsp_resp  <= BRESP;
      rsp_last  <= 1'b1;
    end else if (r_hs_s) begin
      rsp_valid <= 1'b1;
      rsp_write <= 1'b0;
      rsp_id    <= RID;
      rsp_data  <= RDATA;
      rsp_resp  <= RRESP;
      rsp_last  <= RLAST;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef AXI4_MASTER_ENGINE_ERRCNT_EN
  // Count SLVERR/DECERR responses (saturating) and latch a sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt  <= 16'h0000;
      err_flag <= 1'b0;
    end else if ((b_hs_s && BRESP[1]) || (r_hs_s && RRESP[1])) begin
      err_flag <= 1'b1;
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi4_master_engine.sv
// Scoreboard bench for axi4_master_engine: stimulus tasks push expected AW/AR/W
// and response records; a negedge monitor pops and compares on each handshake.
module tb_axi4_master_engine;

  logic        clock, reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_last;
  logic [3:0]  rsp_id;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY, BVALID, BREADY, RLAST, RVALID, RREADY;
`ifdef AXI4_MASTER_ENGINE_ERRCNT_EN
  logic [15:0] err_cnt;
  logic        err_flag;
`endif

  axi4_master_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
    .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
`ifdef AXI4_MASTER_ENGINE_ERRCNT_EN
    , .err_cnt(err_cnt), .err_flag(err_flag)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [48:0] aw_q[$];
  logic [48:0] ar_q[$];
  logic [72:0] w_q[$];
  logic [71:0] rsp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name, input logic [127:0] act);
    total++;
    bad++;
    $display("FAIL %s: got unexpected handshake %0h expected none", name, act);
  endtask

  // Scoreboard monitor: every handshake seen here completes at the next posedge.
  always @(negedge clock) begin
    if (AWVALID && AWREADY) begin
      if (aw_q.size() == 0) extra("aw", 128'({AWADDR, AWID, AWLEN, AWSIZE, AWBURST}));
      else chk("aw", 128'({AWADDR, AWID, AWLEN, AWSIZE, AWBURST}), 128'(aw_q.pop_front()));
    end
    if (ARVALID && ARREADY) begin
      if (ar_q.size() == 0) extra("ar", 128'({ARADDR, ARID, ARLEN, ARSIZE, ARBURST}));
      else chk("ar", 128'({ARADDR, ARID, ARLEN, ARSIZE, ARBURST}), 128'(ar_q.pop_front()));
    end
    if (WVALID && WREADY) begin
      if (w_q.size() == 0) extra("w", 128'({WDATA, WSTRB, WLAST}));
      else chk("w", 128'({WDATA, WSTRB, WLAST}), 128'(w_q.pop_front()));
    end
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) extra("rsp", 128'({rsp_write, rsp_id, rsp_data, rsp_resp, rsp_last}));
      else chk("rsp", 128'({rsp_write, rsp_id, rsp_data, rsp_resp, rsp_last}), 128'(rsp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len);
    bit done = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_id = id; cmd_len = len;
    cmd_size = 3'd3; cmd_burst = 2'b01;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (cmd_ready) begin
        if (wr) aw_q.push_back({addr, id, len, 3'd3, 2'b01});
        else ar_q.push_back({addr, id, len, 3'd3, 2'b01});
        done = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 128'(done), 128'(1'b1));
  endtask

  task automatic send_wd(input logic [63:0] data, input logic [7:0] strb, input logic last);
    bit done = 1'b0;
    wd_valid = 1'b1; wd_data = data; wd_strb = strb;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (wd_ready) begin
        w_q.push_back({data, strb, last});
        done = 1'b1;
      end
      tick();
    end
    wd_valid = 1'b0;
    chk("wd_accept", 128'(done), 128'(1'b1));
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    bit done = 1'b0;
    BVALID = 1'b1; BID = id; BRESP = resp;
    rsp_q.push_back({1'b1, id, 64'h0, resp, 1'b1});
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (BREADY) done = 1'b1;
      tick();
    end
    BVALID = 1'b0;
    chk("b_accept", 128'(done), 128'(1'b1));
  endtask

  task automatic wait_r();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (RREADY) done = 1'b1;
      tick();
    end
    RVALID = 1'b0;
    chk("r_accept", 128'(done), 128'(1'b1));
  endtask

  task automatic send_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                        input logic last);
    RVALID = 1'b1; RID = id; RDATA = data; RRESP = resp; RLAST = last;
    rsp_q.push_back({1'b0, id, data, resp, last});
    wait_r();
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_id = 4'h0;
    cmd_len = 8'h00; cmd_size = 3'd0; cmd_burst = 2'b00;
    wd_valid = 1'b0; wd_data = 64'h0; wd_strb = 8'h00; rsp_ready = 1'b1;
    AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
    BID = 4'h0; BRESP = 2'b00; BVALID = 1'b0;
    RID = 4'h0; RDATA = 64'h0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valids", 128'({AWVALID, WVALID, ARVALID, rsp_valid, BREADY, RREADY}), 128'(6'b0));
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b0));
    chk("rst_addr", 128'({AWADDR, ARADDR, WDATA}), 128'(0));
`ifdef AXI4_MASTER_ENGINE_ERRCNT_EN
    chk("rst_err", 128'({err_cnt, err_flag}), 128'(17'h0));
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));

    // Single write, len 0
    issue_cmd(1'b1, 32'h1000, 4'd3, 8'd0);
    send_wd(64'hA5A5, 8'hFF, 1'b1);
    send_b(4'd3, 2'b00);
    repeat (4) tick();

    // Read burst, len 3
    issue_cmd(1'b0, 32'h2000, 4'd5, 8'd3);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) send_r(4'd5, 64'(i), 2'b00, (i == 3));
    chk("rd_cnt_zero", 128'(dut.rd_cnt_r), 128'(0));
    repeat (3) tick();

    // Outstanding limit: four reads fill the read side
    for (int i = 1; i <= 4; i++) issue_cmd(1'b0, 32'h3000 + 32'(i * 16), 4'(i), 8'd0);
    cmd_write = 1'b0;
    #1;
    chk("limit_closed", 128'(cmd_ready), 128'(1'b0));
    repeat (3) tick();
    chk("limit_still_closed", 128'(cmd_ready), 128'(1'b0));
    send_r(4'd1, 64'h11, 2'b00, 1'b1);
    chk("limit_reopen", 128'(cmd_ready), 128'(1'b1));
    issue_cmd(1'b0, 32'h3050, 4'd5, 8'd0);
    for (int i = 2; i <= 5; i++) send_r(4'(i), 64'h10 + 64'(i), 2'b00, 1'b1);
    repeat (3) tick();

    // Backpressure and B-over-R priority
    issue_cmd(1'b1, 32'h6000, 4'd7, 8'd0);
    send_wd(64'h7777, 8'h0F, 1'b1);
    issue_cmd(1'b0, 32'h6100, 4'd6, 8'd3);
    repeat (2) tick();
    rsp_ready = 1'b0;
    send_r(4'd6, 64'h100, 2'b00, 1'b0);
    RVALID = 1'b1; RID = 4'd6; RDATA = 64'h101; RRESP = 2'b00; RLAST = 1'b0;
    rsp_q.push_back({1'b0, 4'd6, 64'h101, 2'b00, 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rready_low", 128'(RREADY), 128'(1'b0));
      chk("bp_rsp_stable", 128'({rsp_valid, rsp_data}), 128'({1'b1, 64'h100}));
    end
    rsp_ready = 1'b1;
    wait_r();
    rsp_ready = 1'b0;
    BVALID = 1'b1; BID = 4'd7; BRESP = 2'b00;
    rsp_q.push_back({1'b1, 4'd7, 64'h0, 2'b00, 1'b1});
    RVALID = 1'b1; RID = 4'd6; RDATA = 64'h102; RRESP = 2'b01; RLAST = 1'b0;
    rsp_q.push_back({1'b0, 4'd6, 64'h102, 2'b01, 1'b0});
    tick();
    chk("full_readies", 128'({BREADY, RREADY}), 128'(2'b00));
    rsp_ready = 1'b1;
    #1;
    chk("b_priority", 128'({BREADY, RREADY}), 128'(2'b10));
    tick();
    BVALID = 1'b0;
    wait_r();
    send_r(4'd6, 64'h103, 2'b00, 1'b1);
    repeat (4) tick();

    // Write data gating and an 8-beat burst
    AWREADY = 1'b0;
    wd_valid = 1'b1; wd_data = 64'h1000; wd_strb = 8'hFF;
    tick();
    chk("wd_gate_no_cmd", 128'(wd_ready), 128'(1'b0));
    issue_cmd(1'b1, 32'h4000, 4'd8, 8'd7);
    tick();
    chk("wd_gate_aw_pending", 128'({AWVALID, wd_ready}), 128'(2'b10));
    w_q.push_back({64'h1000, 8'hFF, 1'b0});
    AWREADY = 1'b1;
    begin
      bit done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
        #1;
        if (wd_ready) done = 1'b1;
        tick();
      end
      wd_valid = 1'b0;
      chk("wd_gate_open", 128'(done), 128'(1'b1));
    end
    for (int i = 1; i < 8; i++) send_wd(64'h1000 + 64'(i), 8'hFF, (i == 7));
    send_b(4'd8, 2'b00);
    repeat (4) tick();

    // Reset after 2 of 4 write beats
    issue_cmd(1'b1, 32'h5000, 4'd9, 8'd3);
    send_wd(64'h5000, 8'hFF, 1'b0);
    send_wd(64'h5001, 8'hFF, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valids", 128'({AWVALID, WVALID, ARVALID, rsp_valid}), 128'(4'b0));
    chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'(1'b0));
    chk("mid_rst_counters", 128'({dut.wr_cnt_r, dut.len_cnt_r, dut.beat_r}), 128'(0));
    reset = 1'b0;
    cmd_write = 1'b1;
    #1;
    chk("mid_rst_cmd_reopen", 128'(cmd_ready), 128'(1'b1));
    repeat (3) tick();
    chk("mid_rst_no_w", 128'(WVALID), 128'(1'b0));

    // SLVERR write response
    issue_cmd(1'b1, 32'h7000, 4'd2, 8'd0);
    send_wd(64'hBEEF, 8'h03, 1'b1);
    send_b(4'd2, 2'b10);
    repeat (4) tick();
`ifdef AXI4_MASTER_ENGINE_ERRCNT_EN
    chk("err_after_slverr", 128'({err_cnt, err_flag}), 128'({16'd1, 1'b1}));
`endif

    chk("aw_q_drained", 128'(aw_q.size()), 128'(0));
    chk("ar_q_drained", 128'(ar_q.size()), 128'(0));
    chk("w_q_drained", 128'(w_q.size()), 128'(0));
    chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_master_engine.md
Name: axi4_master_engine

Overview:
Parametrised, synthesizable AXI4 initiator engine. It succeeds the DPI-driven master BFM core and generalises it in address, data and ID width and in outstanding depth. It adds the write-data and write-response channels, which that core does not drive. A simple valid/ready command interface feeds it from a testbench proxy or on-chip traffic generator, and it drives a full AW/W/B/AR/R subset with per-direction outstanding limits.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width (power of two, 8..1024)
ID_WIDTH, 4, AXI ID width
MAX_OUTSTANDING, 4, max in-flight bursts per direction (power of two, 1..16)

Ports:
clock  input  1  sole clock
reset  input  1  synchronous active-high reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when valid&ready
cmd_write  input  1  1=write burst, 0=read burst
cmd_addr  input  ADDR_WIDTH  burst start address
cmd_id  input  ID_WIDTH  transaction ID
cmd_len  input  8  AXLEN (beats-1)
cmd_size  input  3  AXSIZE
cmd_burst  input  2  AXBURST
wd_valid  input  1  write beat valid
wd_ready  output  1  write beat accepted
wd_data  input  DATA_WIDTH  write beat data
wd_strb  input  DATA_WIDTH/8  write beat strobes
rsp_valid  output  1  response valid (read beat or write completion)
rsp_ready  input  1  response consumer ready
rsp_write  output  1  1=B response, 0=R beat
rsp_id  output  ID_WIDTH  BID/RID
rsp_data  output  DATA_WIDTH  RDATA (0 for B)
rsp_resp  output  2  BRESP/RRESP
rsp_last  output  1  RLAST (1 for B)
AWADDR/AWID/AWLEN/AWSIZE/AWBURST/AWVALID  output  per AXI4  write address channel
AWREADY  input  1
WDATA/WSTRB/WLAST/WVALID  output  per AXI4  write data channel
WREADY  input  1
BID/BRESP/BVALID  input  per AXI4  write response channel
BREADY  output  1
ARADDR/ARID/ARLEN/ARSIZE/ARBURST/ARVALID  output  per AXI4  read address channel
ARREADY  input  1
RID/RDATA/RRESP/RLAST/RVALID  input  per AXI4  read data channel
RREADY  output  1

Behaviour:
- Reset: all VALIDs, BREADY, RREADY, rsp_valid 0; cmd_ready 0 during reset; outstanding counters, beat counter and len FIFO cleared; address/data outputs 0. Reset mid-burst abandons the burst with no further beats issued.
- Command: cmd_ready = !reset & AW/AR slot free for cmd_write & that direction's outstanding < MAX_OUTSTANDING. Accept registers into AW or AR; AxVALID rises the next cycle and holds with stable payload until AxREADY. Per-direction throughput: 1 command per cycle with zero-bubble reload on handshake.
- Outstanding: wr_cnt increments on AW handshake and decrements on B handshake (rsp path). rd_cnt increments on AR handshake and decrements on R handshake with RLAST. Simultaneous inc/dec leaves the count unchanged. Count never exceeds MAX_OUTSTANDING.
- W path: AW-accepted AWLEN is pushed into a MAX_OUTSTANDING-deep len FIFO. wd_ready = WREADY-path free & len FIFO non-empty; W must never precede its AW acceptance. Output register stage: WVALID/WDATA/WSTRB held until WREADY. Beat counter asserts WLAST on beat == len; the FIFO pops on the WLAST handshake. AWLEN=0 gives a single beat with WLAST=1.
- Response merge: one-entry output register. B has priority over R when both are pending. BREADY/RREADY are asserted only when the register is empty or emptying (rsp_ready & rsp_valid). No response is dropped; rsp_valid holds until rsp_ready.
- Responses are not checked against issued IDs. Unexpected B/R with count 0 is passed through and the counter saturates at 0.

Optional Feature:
AXI4_MASTER_ENGINE_ERRCNT_EN: when defined, adds outputs err_cnt (16) and err_flag (1). err_cnt counts B/R handshakes with resp >= 2 (SLVERR/DECERR) and saturates at 0xFFFF. err_flag is sticky and set on the first error. Both clear on reset. When undefined, the ports and logic are absent.

Test Plan:
- Single write: cmd addr 0x1000, len 0, id 3; wd data 0xA5A5, strb 0xFF; B OKAY -> one AW, one W with WLAST=1, rsp_write=1 id=3 resp=0.
- Read burst: addr 0x2000, len 3, slave returns 4 beats 0..3 with RLAST on beat 3 -> 4 rsp beats, data in order, rsp_last only on 4th, rd_cnt back to 0.
- Outstanding limit: 5 reads back-to-back with MAX_OUTSTANDING=4 and ARREADY=1 but no R -> cmd_ready 0 after the 4th accept; reopens the cycle after the first RLAST handshake.
- Backpressure: rsp_ready=0 for 10 cycles during a read burst -> RREADY low, rsp_data stable, no beat lost; simultaneous B and R prefers B.
- Write data gating: wd_valid asserted before the write command -> wd_ready 0 until AW accepted; burst len 7 produces WLAST on 8th beat.
- Reset mid-burst: assert reset after 2 of 4 W beats -> all VALIDs 0 the next cycle, counters 0, cmd_ready 1 after reset deasserts; with errcnt enabled, a SLVERR B sets err_flag and err_cnt=1.
